// File: rtl/horizontal_tf_sched.sv
// rtl/horizontal_tf_sched.sv - stage-0 sequencer for the horizontal twiddle-factor datapath
// Runs one pass of PASS_CYC advance cycles, drains MUL_LAT cycles, then pulses done.
module horizontal_tf_sched #(
  parameter int MUL_LAT  = 6,
  parameter int PASS_CYC = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       CEN,
  input  logic [3:0] stage_counter,
  output logic       busy,
  output logic       done,
  output logic [1:0] cnt,
  output logic [3:0] group_cnt,
  output logic [1:0] tf_order_cnt,
  output logic       fb_sel,
  output logic       const_bypass,
  output logic       const_cap,
  output logic       horizontal_en,
  output logic       wr_valid
);

  localparam int IW = $clog2(PASS_CYC);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t               state_q, state_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [3:0]           drain_q, drain_d;
  logic                 hen_q, hen_d;
  logic [MUL_LAT-1:0]   sr_q, sr_d;
  logic                 run, adv, abort, sr_in;

  always_comb begin
    run     = (state_q == RUN);
    adv     = run && !CEN;
    abort   = ((state_q == RUN) || (state_q == DRAIN)) && (stage_counter != 4'd0);
    state_d = state_q;
    idx_d   = idx_q;
    drain_d = drain_q;
    hen_d   = hen_q;
    sr_in   = run & hen_q & ~CEN;
    sr_d    = MUL_LAT'({sr_q, sr_in});

    case (state_q)
      IDLE: begin
        if (start && (stage_counter == 4'd0)) begin
          state_d = RUN;
          idx_d   = '0;
        end
      end
      RUN: begin
        if (adv) begin
          idx_d = idx_q + 1'b1;
          if (idx_q == IW'(2)) hen_d = 1'b1;
          // PASS_CYC need not be a power of two, so wrap explicitly
          if (idx_q == IW'(PASS_CYC - 1)) begin
            state_d = DRAIN;
            idx_d   = '0;
            drain_d = 4'd0;
          end
        end
      end
      DRAIN: begin
        if (drain_q == 4'(MUL_LAT - 1)) state_d = DONE;
        else                            drain_d = drain_q + 1'b1;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (state_d != RUN) hen_d = 1'b0;

    if (abort) begin
      state_d = IDLE;
      idx_d   = '0;
      drain_d = 4'd0;
      hen_d   = 1'b0;
      sr_d    = '0;
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      drain_q <= 4'd0;
      hen_q   <= 1'b0;
      sr_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      drain_q <= drain_d;
      hen_q   <= hen_d;
      sr_q    <= sr_d;
    end
  end

  assign cnt           = run ? idx_q[1:0] : 2'd0;
  assign group_cnt     = run ? idx_q[3:0] : 4'd0;
  assign tf_order_cnt  = run ? idx_q[3:2] : 2'd0;
  assign fb_sel        = (tf_order_cnt != 2'd0);
  assign const_bypass  = run && (group_cnt == 4'd0);
  assign const_cap     = adv && (group_cnt == 4'd0);
  assign busy          = (state_q == RUN) || (state_q == DRAIN);
  assign done          = (state_q == DONE);
  assign horizontal_en = hen_q;
  assign wr_valid      = sr_q[MUL_LAT-1];

endmodule

// File: tb/tb_horizontal_tf_sched.sv
// tb/tb_horizontal_tf_sched.sv - self-checking bench for horizontal_tf_sched
// Model tracks pass position and a delay queue; literal checks pin pass timing.
module tb_horizontal_tf_sched;
  localparam int ML = 6;
  localparam int PC = 64;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic       CEN = 1'b0;
  logic [3:0] stage_counter = 4'd0;
  logic       busy, done, fb_sel, const_bypass, const_cap, horizontal_en, wr_valid;
  logic [1:0] cnt, tf_order_cnt;
  logic [3:0] group_cnt;

  horizontal_tf_sched #(.MUL_LAT(ML), .PASS_CYC(PC)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .CEN(CEN), .stage_counter(stage_counter),
    .busy(busy), .done(done), .cnt(cnt), .group_cnt(group_cnt), .tf_order_cnt(tf_order_cnt),
    .fb_sel(fb_sel), .const_bypass(const_bypass), .const_cap(const_cap),
    .horizontal_en(horizontal_en), .wr_valid(wr_valid)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0, cyc = 0;
  int t_start = 0, m_done_cyc = -1, dut_done_cyc = -1;
  int dut_done_n = 0, hen_n = 0, wr_n = 0, wr_first = -1, cap_n = 0;

  // model: pass position in advance cycles, drain cycles elapsed, wr_valid delay line
  bit m_busy, m_done;
  int m_pos, m_after;
  bit wq[$];

  task automatic chk(input string n, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", n, cyc, act, exp);
    end
  endtask

  task automatic m_clear();
    m_busy = 0; m_done = 0; m_pos = 0; m_after = 0;
    wq.delete();
    for (int i = 0; i < ML; i++) wq.push_back(1'b0);
  endtask

  task automatic m_step();
    bit run, in_b;
    run  = m_busy && (m_pos < PC);
    in_b = run && (m_pos >= 3) && !CEN;
    if (rst_n || (m_busy && stage_counter != 4'd0)) begin
      m_clear();
      return;
    end
    wq.push_back(in_b);
    void'(wq.pop_front());
    if (m_done) m_done = 0;
    else if (m_busy) begin
      if (run) begin
        if (!CEN) m_pos++;
      end else begin
        m_after++;
        if (m_after == ML) begin
          m_busy = 0; m_done = 1; m_done_cyc = cyc;
        end
      end
    end else if (start && stage_counter == 4'd0) begin
      m_busy = 1; m_pos = 0; m_after = 0;
    end
  endtask

  initial begin
    m_clear();
    forever begin
      @(posedge clk);
      cyc++;
      m_step();
    end
  end

  initial begin
    bit run;
    int p;
    forever begin
      @(negedge clk);
      if (rst_n) m_clear();
      run = m_busy && (m_pos < PC);
      p   = m_pos;
      chk("busy",          busy,          m_busy);
      chk("done",          done,          m_done);
      chk("cnt",           cnt,           run ? p % 4 : 0);
      chk("group_cnt",     group_cnt,     run ? p % 16 : 0);
      chk("tf_order_cnt",  tf_order_cnt,  run ? (p / 4) % 4 : 0);
      chk("fb_sel",        fb_sel,        run && (p % 16) >= 4);
      chk("const_bypass",  const_bypass,  run && (p % 16) == 0);
      chk("const_cap",     const_cap,     run && !CEN && (p % 16) == 0);
      chk("horizontal_en", horizontal_en, run && p >= 3);
      chk("wr_valid",      wr_valid,      wq[0]);
      if (done) begin dut_done_n++; dut_done_cyc = cyc; end
      if (horizontal_en) hen_n++;
      if (const_cap) cap_n++;
      if (wr_valid) begin
        wr_n++;
        if (wr_first < 0) wr_first = cyc;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_stats();
    dut_done_n = 0; hen_n = 0; wr_n = 0; wr_first = -1; cap_n = 0;
    dut_done_cyc = -1; m_done_cyc = -1;
  endtask

  task automatic pulse_start();
    clr_stats();
    start = 1'b1;
    t_start = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (dut_done_n == 0 && n < 300) begin
      tick();
      n++;
    end
    if (dut_done_n == 0) chk("done_timeout", dut_done_n, 1);
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_wr_valid", wr_valid, 0);
    rst_n = 1'b0;
    tick();

    // plain pass
    pulse_start();
    wait_done();
    chk("p1_latency", dut_done_cyc - t_start, 71);
    chk("p1_model_latency", m_done_cyc - t_start, 71);
    chk("p1_hen_cycles", hen_n, 61);
    chk("p1_wr_cycles", wr_n, 61);
    chk("p1_wr_first", wr_first - t_start, 10);
    chk("p1_cap_pulses", cap_n, 4);

    // five-cycle stall at idx 20
    pulse_start();
    repeat (20) tick();
    CEN = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_group", group_cnt, 4);
      chk("stall_tf", tf_order_cnt, 1);
      chk("stall_cnt", cnt, 0);
      chk("stall_cap", const_cap, 0);
      tick();
    end
    CEN = 1'b0;
    wait_done();
    chk("stall_latency", dut_done_cyc - t_start, 76);
    chk("stall_cap_pulses", cap_n, 4);
    chk("stall_hen_cycles", hen_n, 66);
    chk("stall_wr_cycles", wr_n, 61);

    // abort at idx 30, then a full pass
    pulse_start();
    repeat (30) tick();
    stage_counter = 4'd1;
    tick();
    chk("abort_busy", busy, 0);
    chk("abort_hen", horizontal_en, 0);
    chk("abort_group", group_cnt, 0);
    chk("abort_wr", wr_valid, 0);
    stage_counter = 4'd0;
    repeat (20) tick();
    chk("abort_no_done", dut_done_n, 0);
    pulse_start();
    wait_done();
    chk("post_abort_latency", dut_done_cyc - t_start, 71);

    // start during RUN is ignored
    pulse_start();
    repeat (10) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done();
    chk("restart_latency", dut_done_cyc - t_start, 71);

    // start outside stage 0 is ignored
    tick();
    clr_stats();
    stage_counter = 4'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    chk("stage2_busy", busy, 0);
    chk("stage2_no_done", dut_done_n, 0);
    stage_counter = 4'd0;
    tick();

    // reset mid-pass at idx 40
    pulse_start();
    repeat (40) tick();
    rst_n = 1'b1;
    #1;
    chk("mrst_busy", busy, 0);
    chk("mrst_hen", horizontal_en, 0);
    chk("mrst_wr", wr_valid, 0);
    chk("mrst_group", group_cnt, 0);
    tick();
    tick();
    rst_n = 1'b0;
    wr_n = 0;
    repeat (20) tick();
    chk("mrst_no_wr", wr_n, 0);
    chk("mrst_no_done", dut_done_n, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
